// File: rtl/scaler_pkg.sv
// Shared constants and types for the scaler datapath.
package scaler_pkg;

  localparam int unsigned PIX_W      = 24;
  localparam int unsigned COEF_W     = 17;
  localparam int unsigned COEF_FRAC  = 16;
  localparam int unsigned INTERP_LAT = 4;

  localparam int unsigned CH_W   = 8;
  localparam int unsigned PROD_W = 25;
  localparam int unsigned SUM_W  = 27;

  // Half an LSB of the Q1.16 result, for round-to-nearest.
  localparam logic [SUM_W-1:0] ROUND_CONST = 27'd32768;
  localparam logic [CH_W-1:0]  SAT_VAL     = 8'd255;

  // Four neighbour weights: [0] top-left, [1] top-right, [2] bottom-left, [3] bottom-right.
  typedef logic [3:0][COEF_W-1:0] coef_set_t;

endpackage

// File: rtl/bilinear_mac.sv
// One 8-bit channel: weighted products, then round, saturate and register.
module bilinear_mac
  import scaler_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 prod_en_i,
  input  logic                 out_en_i,
  input  coef_set_t            coef_i,
  input  logic [3:0][CH_W-1:0] pix_i,
  output logic [CH_W-1:0]      data_o
);

  logic [3:0][PROD_W-1:0]        prod_q;
  logic [SUM_W-1:0]              sum;
  logic [SUM_W-COEF_FRAC-1:0]    res;
  logic [CH_W-1:0]               data_d;
  logic [CH_W-1:0]               data_q;

  // Register the four weight*pixel products.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q <= '0;
    end else if (prod_en_i) begin
      for (int i = 0; i < 4; i++) begin
        prod_q[i] <= PROD_W'(coef_i[i]) * PROD_W'(pix_i[i]);
      end
    end
  end

  // Sum with rounding, drop the fraction and clamp anything above full scale.
  always_comb begin
    sum = ROUND_CONST;
    for (int i = 0; i < 4; i++) begin
      sum = sum + SUM_W'(prod_q[i]);
    end
    res    = sum[SUM_W-1:COEF_FRAC];
    data_d = (|res[SUM_W-COEF_FRAC-1:CH_W]) ? SAT_VAL : res[CH_W-1:0];
  end

  // Output register holds its value across bubbles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (out_en_i) begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bilinear_interp.sv
// Bilinear interpolator: issues line-buffer reads, blends four neighbours per channel,
// and tags the output stream with start-of-frame and end-of-line markers.
module bilinear_interp #(
  parameter int unsigned PIX_W  = scaler_pkg::PIX_W,
  parameter int unsigned LB_LAT = 1
) (
  input  logic                          vin_clk,
  input  logic                          rst,
  input  logic                          frame_sync_n,
  input  logic [15:0]                   vin_xres,
  input  logic [15:0]                   vin_yres,
  input  logic [15:0]                   vout_xres,
  input  logic                          coo_valid,
  input  logic [15:0]                   coordinate_x,
  input  logic [15:0]                   coordinate_y,
  input  logic [scaler_pkg::COEF_W-1:0] coefficient1,
  input  logic [scaler_pkg::COEF_W-1:0] coefficient2,
  input  logic [scaler_pkg::COEF_W-1:0] coefficient3,
  input  logic [scaler_pkg::COEF_W-1:0] coefficient4,
  output logic                          lb_rd_en,
  output logic [15:0]                   lb_rd_x0,
  output logic [15:0]                   lb_rd_x1,
  output logic [15:0]                   lb_rd_y0,
  output logic [15:0]                   lb_rd_y1,
  input  logic [PIX_W-1:0]              lb_p00,
  input  logic [PIX_W-1:0]              lb_p01,
  input  logic [PIX_W-1:0]              lb_p10,
  input  logic [PIX_W-1:0]              lb_p11,
  output logic                          pix_valid,
  output logic [PIX_W-1:0]              pix_data,
  output logic                          pix_sof,
  output logic                          pix_eol
);

  import scaler_pkg::*;

  localparam int unsigned NumCh = PIX_W / CH_W;

  // vld_q[0] is the read strobe (T1), vld_q[INTERP_LAT-1] the output strobe (T4).
  logic [INTERP_LAT-1:0] vld_q;
  logic [15:0]           x0_q, x1_q, y0_q, y1_q;
  logic [15:0]           x1_d, y1_d;
  coef_set_t             coef_q;
  coef_set_t             coef_dly_q [LB_LAT];
  logic [15:0]           out_x_q, out_x_d;
  logic                  sof_pend_q, sof_pend_d;
  logic                  last_x;

  // Right/bottom neighbour addresses, clamped to the last source column/row.
  always_comb begin
    x1_d = coordinate_x + 16'd1;
    y1_d = coordinate_y + 16'd1;
    if (({1'b0, coordinate_x} + 17'd1) >= {1'b0, vin_xres}) x1_d = vin_xres - 16'd1;
    if (({1'b0, coordinate_y} + 17'd1) >= {1'b0, vin_yres}) y1_d = vin_yres - 16'd1;
  end

  // T1: capture addresses and weights; a coordinate arriving with frame_sync_n low is dropped.
  always_ff @(posedge vin_clk) begin
    if (rst) begin
      x0_q   <= '0;
      x1_q   <= '0;
      y0_q   <= '0;
      y1_q   <= '0;
      coef_q <= '0;
    end else if (coo_valid && frame_sync_n) begin
      x0_q   <= coordinate_x;
      x1_q   <= x1_d;
      y0_q   <= coordinate_y;
      y1_q   <= y1_d;
      coef_q <= {coefficient4, coefficient3, coefficient2, coefficient1};
    end
  end

  // Valid pipeline; frame restart flushes everything in flight.
  always_ff @(posedge vin_clk) begin
    if (rst || !frame_sync_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[INTERP_LAT-2:0], coo_valid};
    end
  end

  // T2: delay weights by the line-buffer latency so they meet their pixels.
  always_ff @(posedge vin_clk) begin
    if (rst) begin
      for (int i = 0; i < LB_LAT; i++) coef_dly_q[i] <= '0;
    end else begin
      coef_dly_q[0] <= coef_q;
      for (int i = 1; i < LB_LAT; i++) coef_dly_q[i] <= coef_dly_q[i-1];
    end
  end

  assign last_x = (out_x_q == vout_xres - 16'd1);

  // Output column counter and pending start-of-frame flag.
  always_comb begin
    out_x_d    = out_x_q;
    sof_pend_d = sof_pend_q;
    if (vld_q[INTERP_LAT-1]) begin
      out_x_d    = last_x ? 16'd0 : out_x_q + 16'd1;
      sof_pend_d = 1'b0;
    end
    if (!frame_sync_n) begin
      out_x_d    = '0;
      sof_pend_d = 1'b1;
    end
  end

  // Counter and flag state.
  always_ff @(posedge vin_clk) begin
    if (rst) begin
      out_x_q    <= '0;
      sof_pend_q <= 1'b1;
    end else begin
      out_x_q    <= out_x_d;
      sof_pend_q <= sof_pend_d;
    end
  end

  for (genvar ch = 0; ch < NumCh; ch++) begin : g_ch
    logic [3:0][CH_W-1:0] pix_ch;
    assign pix_ch = {lb_p11[ch*CH_W +: CH_W], lb_p10[ch*CH_W +: CH_W],
                     lb_p01[ch*CH_W +: CH_W], lb_p00[ch*CH_W +: CH_W]};

    bilinear_mac u_mac (
      .clk_i     (vin_clk),
      .rst_i     (rst),
      .prod_en_i (vld_q[1]),
      .out_en_i  (vld_q[2]),
      .coef_i    (coef_dly_q[LB_LAT-1]),
      .pix_i     (pix_ch),
      .data_o    (pix_data[ch*CH_W +: CH_W])
    );
  end

  assign lb_rd_en  = vld_q[0];
  assign lb_rd_x0  = x0_q;
  assign lb_rd_x1  = x1_q;
  assign lb_rd_y0  = y0_q;
  assign lb_rd_y1  = y1_q;
  assign pix_valid = vld_q[INTERP_LAT-1];
  assign pix_sof   = pix_valid && sof_pend_q;
  assign pix_eol   = pix_valid && last_x;

endmodule

// File: tb/tb_bilinear_interp.sv
// Directed bench for bilinear_interp with hand-computed expected values.
module tb_bilinear_interp;

  logic        vin_clk = 1'b0;
  logic        rst, frame_sync_n;
  logic [15:0] vin_xres, vin_yres, vout_xres;
  logic        coo_valid;
  logic [15:0] coordinate_x, coordinate_y;
  logic [16:0] coefficient1, coefficient2, coefficient3, coefficient4;
  logic        lb_rd_en;
  logic [15:0] lb_rd_x0, lb_rd_x1, lb_rd_y0, lb_rd_y1;
  logic [23:0] lb_p00, lb_p01, lb_p10, lb_p11;
  logic        pix_valid, pix_sof, pix_eol;
  logic [23:0] pix_data;

  int n_checks = 0;
  int n_fail   = 0;

  bilinear_interp #(.PIX_W(24), .LB_LAT(1)) dut (
    .vin_clk      (vin_clk),
    .rst          (rst),
    .frame_sync_n (frame_sync_n),
    .vin_xres     (vin_xres),
    .vin_yres     (vin_yres),
    .vout_xres    (vout_xres),
    .coo_valid    (coo_valid),
    .coordinate_x (coordinate_x),
    .coordinate_y (coordinate_y),
    .coefficient1 (coefficient1),
    .coefficient2 (coefficient2),
    .coefficient3 (coefficient3),
    .coefficient4 (coefficient4),
    .lb_rd_en     (lb_rd_en),
    .lb_rd_x0     (lb_rd_x0),
    .lb_rd_x1     (lb_rd_x1),
    .lb_rd_y0     (lb_rd_y0),
    .lb_rd_y1     (lb_rd_y1),
    .lb_p00       (lb_p00),
    .lb_p01       (lb_p01),
    .lb_p10       (lb_p10),
    .lb_p11       (lb_p11),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_sof      (pix_sof),
    .pix_eol      (pix_eol)
  );

  always #5 vin_clk = ~vin_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge vin_clk);
    #1;
  endtask

  // Present one coordinate for a single cycle and wait (bounded) for its pixel.
  // lat counts clock edges including the one that samples coo_valid.
  task automatic send_one(input logic [16:0] c1, c2, c3, c4,
                          input logic [23:0] p00, p01, p10, p11,
                          input logic [15:0] cx, cy,
                          output logic [23:0] data, output logic sof, eol,
                          output int lat);
    lb_p00 = p00; lb_p01 = p01; lb_p10 = p10; lb_p11 = p11;
    coefficient1 = c1; coefficient2 = c2; coefficient3 = c3; coefficient4 = c4;
    coordinate_x = cx; coordinate_y = cy;
    coo_valid = 1'b1;
    tick();
    coo_valid = 1'b0;
    lat = 1;
    while (!pix_valid && lat < 10) begin
      tick();
      lat++;
    end
    data = pix_data;
    sof  = pix_sof;
    eol  = pix_eol;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] d;
    logic        s, e;
    int          lat;
    logic [31:0] v_vec, s_vec, e_vec;
    int          pv;

    rst = 1'b1; frame_sync_n = 1'b1; coo_valid = 1'b0;
    vin_xres = 16'd1920; vin_yres = 16'd1080; vout_xres = 16'd8;
    coordinate_x = '0; coordinate_y = '0;
    coefficient1 = '0; coefficient2 = '0; coefficient3 = '0; coefficient4 = '0;
    lb_p00 = '0; lb_p01 = '0; lb_p10 = '0; lb_p11 = '0;
    tick();
    tick();
    check_val("rst_pix_valid", pix_valid, 0);
    check_val("rst_pix_sof", pix_sof, 0);
    check_val("rst_pix_eol", pix_eol, 0);
    check_val("rst_lb_rd_en", lb_rd_en, 0);
    check_val("rst_pix_data", pix_data, 0);
    check_val("rst_lb_rd_x1", lb_rd_x1, 0);
    check_val("rst_lb_rd_y1", lb_rd_y1, 0);
    rst = 1'b0;

    // Single-weight pass-through, first pixel carries sof.
    send_one(17'd65536, 17'd0, 17'd0, 17'd0, 24'h123456, 24'h0, 24'h0, 24'h0,
             16'd10, 16'd20, d, s, e, lat);
    check_val("weights_data", d, 32'h123456);
    check_val("weights_latency", lat, 4);
    check_val("weights_sof", s, 1);
    check_val("weights_eol", e, 0);
    tick();
    check_val("bubble_valid", pix_valid, 0);
    check_val("bubble_hold_data", pix_data, 32'h123456);

    // Equal quarter weights: R = (10+20+30+40)/4 = 25 (25.5 truncated after +0.5).
    send_one(17'd16384, 17'd16384, 17'd16384, 17'd16384,
             24'h0A0000, 24'h140000, 24'h1E0000, 24'h280000, 16'd3, 16'd4, d, s, e, lat);
    check_val("blend_data", d, 32'h190000);
    check_val("blend_sof", s, 0);

    // 0.25 + 0.5 rounding offset stays below 1.
    send_one(17'd16384, 17'd16384, 17'd16384, 17'd16384,
             24'h0, 24'h0, 24'h0, 24'h010000, 16'd3, 16'd4, d, s, e, lat);
    check_val("round_data", d, 32'h0);

    // Weight sum 4.0 on white saturates rather than wrapping.
    send_one(17'd65536, 17'd65536, 17'd65536, 17'd65536,
             24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 16'd3, 16'd4, d, s, e, lat);
    check_val("sat_data", d, 32'hFFFFFF);

    // Edge clamping, corner then one column in.
    coordinate_x = 16'd1919; coordinate_y = 16'd1079; coo_valid = 1'b1;
    tick();
    check_val("edge_rd_en", lb_rd_en, 1);
    check_val("edge_x0", lb_rd_x0, 1919);
    check_val("edge_x1", lb_rd_x1, 1919);
    check_val("edge_y0", lb_rd_y0, 1079);
    check_val("edge_y1", lb_rd_y1, 1079);
    coordinate_x = 16'd1918; coordinate_y = 16'd7;
    tick();
    check_val("inner_x1", lb_rd_x1, 1919);
    check_val("inner_y1", lb_rd_y1, 8);
    coo_valid = 1'b0;
    tick();
    check_val("idle_rd_en", lb_rd_en, 0);
    repeat (4) tick();

    // Stream of 16 with an 8-pixel line; restart the frame first.
    frame_sync_n = 1'b0;
    tick();
    frame_sync_n = 1'b1;
    v_vec = '0; s_vec = '0; e_vec = '0;
    coordinate_x = 16'd0; coordinate_y = 16'd0;
    coo_valid = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (i == 15) coo_valid = 1'b0;
      v_vec[i] = pix_valid;
      s_vec[i] = pix_sof;
      e_vec[i] = pix_eol;
    end
    check_val("stream_valid", v_vec, 32'h0007FFF8);
    check_val("stream_sof", s_vec, 32'h00000008);
    check_val("stream_eol", e_vec, 32'h00040400);

    // One pixel so the column counter sits at 1 before the flush.
    send_one(17'd65536, 17'd0, 17'd0, 17'd0, 24'h0000AB, 24'h0, 24'h0, 24'h0,
             16'd1, 16'd1, d, s, e, lat);
    check_val("preflush_data", d, 32'hAB);
    check_val("preflush_sof", s, 0);

    // Three coordinates, then a 2-cycle frame restart; the second restart cycle
    // also carries a coordinate that must be dropped.
    pv = 0;
    coo_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      pv += int'(pix_valid);
    end
    coo_valid = 1'b0; frame_sync_n = 1'b0;
    tick();
    pv += int'(pix_valid);
    coo_valid = 1'b1;
    tick();
    pv += int'(pix_valid);
    coo_valid = 1'b0; frame_sync_n = 1'b1;
    check_val("flush_rd_en", lb_rd_en, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      pv += int'(pix_valid);
    end
    check_val("flush_no_valid", pv, 0);
    check_val("flush_data_kept", pix_data, 32'hAB);

    // With a 1-pixel line, eol only if the counter restarted at 0.
    vout_xres = 16'd1;
    send_one(17'd65536, 17'd0, 17'd0, 17'd0, 24'h0000CD, 24'h0, 24'h0, 24'h0,
             16'd2, 16'd2, d, s, e, lat);
    check_val("postflush_data", d, 32'hCD);
    check_val("postflush_sof", s, 1);
    check_val("postflush_eol", e, 1);
    check_val("postflush_latency", lat, 4);
    vout_xres = 16'd8;
    tick();

    // Reset while a pixel is in flight.
    coordinate_x = 16'd33; coordinate_y = 16'd44; coo_valid = 1'b1;
    tick();
    coo_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_val("midrst_valid", pix_valid, 0);
    check_val("midrst_rd_en", lb_rd_en, 0);
    check_val("midrst_x0", lb_rd_x0, 0);
    check_val("midrst_data", pix_data, 0);
    rst = 1'b0;
    pv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pv += int'(pix_valid);
    end
    check_val("midrst_no_valid", pv, 0);
    send_one(17'd65536, 17'd0, 17'd0, 17'd0, 24'h0000EF, 24'h0, 24'h0, 24'h0,
             16'd5, 16'd5, d, s, e, lat);
    check_val("afterrst_data", d, 32'hEF);
    check_val("afterrst_sof", s, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
